// File: rtl/mig_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mig_arb_pkg
// Description : Shared definitions for the MIG app-interface arbiter: MIG
//               command encodings, sequencer state type and the round-robin
//               selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mig_arb_pkg;

    // MIG app_cmd encodings
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Widest requester vector the round-robin helper handles
    localparam int RR_MAX = 8;

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        IDLE       = 2'd1,
        RD         = 2'd2,
        WR         = 2'd3
    } arb_state_t;

    // Returns {found, index}: first set bit of elig at or after start,
    // wrapping modulo nreq.
    function automatic logic [3:0] rr_pick(
        input logic [RR_MAX-1:0] elig,
        input logic [2:0]        start,
        input int unsigned       nreq
    );
        logic        found;
        logic [2:0]  idx;
        int unsigned cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            cand = (32'(start) + i) % nreq;
            if (!found && (i < nreq) && elig[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage : mig_arb_pkg
`default_nettype wire

// File: rtl/mig_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mig_arb_tag_fifo
// Description : Synchronous FIFO holding the requester id of each read issued
//               to the MIG, so in-order read data can be routed back.
//               Simultaneous push and pop are both honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Qualify requests against occupancy and advance pointers/count
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : mig_arb_tag_fifo
`default_nettype wire

// File: rtl/mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_arbiter
// Description : Round-robin arbiter/sequencer sharing the MIG app_* interface
//               between NREQ requesters. Waits for calibration, runs the
//               command and write-data handshakes, and routes in-order read
//               data back through a tag FIFO.
//               Optional: MIG_ARB_STATS_EN adds stat_wr_cnt/stat_rd_cnt/
//               stat_err outputs. MIG_ARB_PROTOCOL_CHECK enables the
//               simulation assertion on read data with no outstanding tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_app_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256,
    parameter int TAG_DEPTH  = 8,
    parameter int IDW        = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           init_calib_complete,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0]                req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NREQ*DATA_WIDTH/8-1:0]   req_wmask,
    output logic                           rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          app_addr,
    output logic [2:0]                     app_cmd,
    output logic                           app_en,
    input  logic                           app_rdy,
    output logic [DATA_WIDTH-1:0]          app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]        app_wdf_mask,
    output logic                           app_wdf_wren,
    output logic                           app_wdf_end,
    input  logic                           app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]          app_rd_data,
    input  logic                           app_rd_data_valid,
    output logic                           busy
`ifdef MIG_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_wr_cnt,
    output logic [31:0]                    stat_rd_cnt,
    output logic                           stat_err
`endif
);

    localparam int MW    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    arb_state_t              state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [NREQ-1:0]         req_ready_q, req_ready_d;
    logic                    app_en_q, app_en_d;
    logic [2:0]              app_cmd_q, app_cmd_d;
    logic [ADDR_WIDTH-1:0]   app_addr_q, app_addr_d;
    logic [DATA_WIDTH-1:0]   app_wdf_data_q, app_wdf_data_d;
    logic [MW-1:0]           app_wdf_mask_q, app_wdf_mask_d;
    logic                    app_wdf_wren_q, app_wdf_wren_d;
    logic                    cmd_done_q, cmd_done_d;
    logic                    wdf_done_q, wdf_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    tag_push, tag_pop, tag_full, tag_empty;
    logic [IDW-1:0]          tag_head;
    logic [CNT_W-1:0]        tag_count, tag_count_nxt;

    logic [RR_MAX-1:0]       elig_ext;
    logic [3:0]              pick;
    int unsigned             grant_idx;
    logic                    cmd_acc, wdf_acc;

    assign req_ready    = req_ready_q;
    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_data = app_wdf_data_q;
    assign app_wdf_mask = app_wdf_mask_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = busy_q;

    mig_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDW)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_push),
        .push_data (grant_id_q),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // Arbitration and MIG command/write-data sequencing
    always_comb begin
        elig_ext = '0;
        // Reads are held off while no tag slot is free; writes never need one
        elig_ext[NREQ-1:0] = req_valid & (req_write | {NREQ{~tag_full}});
        pick      = rr_pick(elig_ext, 3'(rr_ptr_q), NREQ);
        grant_idx = 32'(pick[2:0]);
        cmd_acc   = app_en_q & app_rdy;
        wdf_acc   = app_wdf_wren_q & app_wdf_rdy;

        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        req_ready_d    = '0;
        app_en_d       = 1'b0;
        app_cmd_d      = app_cmd_q;
        app_addr_d     = app_addr_q;
        app_wdf_data_d = app_wdf_data_q;
        app_wdf_mask_d = app_wdf_mask_q;
        app_wdf_wren_d = 1'b0;
        cmd_done_d     = cmd_done_q;
        wdf_done_d     = wdf_done_q;
        tag_push       = 1'b0;

        case (state_q)
            WAIT_CALIB: begin
                if (init_calib_complete) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!init_calib_complete) begin
                    state_d = WAIT_CALIB;
                end else if (pick[3]) begin
                    req_ready_d[grant_idx] = 1'b1;
                    rr_ptr_d       = IDW'((grant_idx + 1) % NREQ);
                    grant_id_d     = IDW'(grant_idx);
                    app_addr_d     = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    app_wdf_data_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    app_wdf_mask_d = req_wmask[grant_idx*MW +: MW];
                    app_cmd_d      = req_write[grant_idx] ? CMD_WR : CMD_RD;
                    cmd_done_d     = 1'b0;
                    wdf_done_d     = 1'b0;
                    state_d        = req_write[grant_idx] ? WR : RD;
                end
            end
            RD: begin
                // First RD cycle raises app_en; it then holds until accepted
                app_en_d = !cmd_acc;
                if (cmd_acc) begin
                    tag_push = 1'b1;
                    state_d  = IDLE;
                end
            end
            WR: begin
                // Command and data channels retire independently
                cmd_done_d     = cmd_done_q | cmd_acc;
                wdf_done_d     = wdf_done_q | wdf_acc;
                app_en_d       = !cmd_done_d;
                app_wdf_wren_d = !wdf_done_d;
                if (cmd_done_d && wdf_done_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_CALIB;
        endcase
    end

    // Read-return path: pop the oldest tag alongside each data beat
    always_comb begin
        tag_pop     = app_rd_data_valid && !tag_empty;
        rsp_valid_d = tag_pop;
        rsp_id_d    = tag_pop ? tag_head : rsp_id_q;
        rsp_data_d  = tag_pop ? app_rd_data : rsp_data_q;
        err_d       = err_q | (app_rd_data_valid && tag_empty);
        tag_count_nxt = tag_count + CNT_W'(tag_push) - CNT_W'(tag_pop);
        busy_d      = (state_d == RD) || (state_d == WR) || (tag_count_nxt != '0);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= WAIT_CALIB;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            req_ready_q    <= '0;
            app_en_q       <= 1'b0;
            app_cmd_q      <= '0;
            app_addr_q     <= '0;
            app_wdf_data_q <= '0;
            app_wdf_mask_q <= '0;
            app_wdf_wren_q <= 1'b0;
            cmd_done_q     <= 1'b0;
            wdf_done_q     <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            req_ready_q    <= req_ready_d;
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_data_q <= app_wdf_data_d;
            app_wdf_mask_q <= app_wdf_mask_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            cmd_done_q     <= cmd_done_d;
            wdf_done_q     <= wdf_done_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

`ifdef MIG_ARB_STATS_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    // Count MIG commands accepted, by type
    always_comb begin
        wr_cnt_d = wr_cnt_q + 32'((state_q == WR) && cmd_acc);
        rd_cnt_d = rd_cnt_q + 32'((state_q == RD) && cmd_acc);
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign stat_wr_cnt = wr_cnt_q;
    assign stat_rd_cnt = rd_cnt_q;
    assign stat_err    = err_q;
`endif

`ifdef MIG_ARB_PROTOCOL_CHECK
    // Read data must always have an outstanding tag to route it
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(app_rd_data_valid && tag_empty))
                else $error("mig_app_arbiter: read data with no outstanding tag");
        end
    end
`endif

endmodule : mig_app_arbiter
`default_nettype wire

// File: tb/tb_mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_app_arbiter
// Description : Directed self-checking bench for mig_app_arbiter (NREQ=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_app_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 29;
    localparam int DW   = 256;
    localparam int MW   = DW / 8;
    localparam int IDW  = 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 init_calib_complete = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*AW-1:0]   req_addr  = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ*MW-1:0]   req_wmask = '0;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_data;
    logic [AW-1:0]        app_addr;
    logic [2:0]           app_cmd;
    logic                 app_en;
    logic                 app_rdy = 1'b0;
    logic [DW-1:0]        app_wdf_data;
    logic [MW-1:0]        app_wdf_mask;
    logic                 app_wdf_wren;
    logic                 app_wdf_end;
    logic                 app_wdf_rdy = 1'b0;
    logic [DW-1:0]        app_rd_data = '0;
    logic                 app_rd_data_valid = 1'b0;
    logic                 busy;
`ifdef MIG_ARB_STATS_EN
    logic [31:0]          stat_wr_cnt;
    logic [31:0]          stat_rd_cnt;
    logic                 stat_err;
`endif

    int total = 0;
    int bad   = 0;

    mig_app_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(8), .IDW(IDW)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .init_calib_complete (init_calib_complete),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_wmask           (req_wmask),
        .rsp_valid           (rsp_valid),
        .rsp_id              (rsp_id),
        .rsp_data            (rsp_data),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .busy                (busy)
`ifdef MIG_ARB_STATS_EN
        ,
        .stat_wr_cnt         (stat_wr_cnt),
        .stat_rd_cnt         (stat_rd_cnt),
        .stat_err            (stat_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_rdy, n_en, ng, na, n0, s0, s1, seen;
        int          en_cnt, wr_cnt, cmd_cnt, wdf_cnt;
        logic [3:0]  gbits;
        logic [DW-1:0] wpat;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst req_ready", DW'(req_ready), '0);
        chk("rst app_en", DW'(app_en), '0);
        chk("rst app_wdf_wren", DW'(app_wdf_wren), '0);
        chk("rst rsp_valid", DW'(rsp_valid), '0);
        chk("rst busy", DW'(busy), '0);
        chk("rst app_addr", DW'(app_addr), '0);
        reset = 1'b0;

        // ---------------- 1: calibration hold-off ----------------
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {29'h20, 29'h10};
        n_rdy = 0; n_en = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (req_ready != '0) n_rdy++;
            if (app_en) n_en++;
        end
        chk("t1 grants before calib", DW'(n_rdy), DW'(0));
        chk("t1 app_en before calib", DW'(n_en), DW'(0));
        init_calib_complete = 1'b1;
        app_rdy = 1'b1;
        tick();
        chk("t1 ready one cycle after calib", DW'(req_ready), DW'(2'b00));
        tick();
        chk("t1 first grant", DW'(req_ready), DW'(2'b01));

        // ---------------- 2: alternating reads ----------------
        gbits = '0;
        gbits[0] = req_ready[1];
        ng = 1; na = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (req_ready != '0 && ng < 4) begin
                gbits[ng] = req_ready[1];
                ng++;
                if (ng == 4) req_valid = 2'b00;
            end
            if (app_en && app_rdy && na < 4) begin
                chk("t2 read cmd", DW'(app_cmd), DW'(3'b001));
                chk("t2 read addr", DW'(app_addr), (na % 2 == 1) ? DW'(29'h20) : DW'(29'h10));
                na++;
            end
        end
        chk("t2 grant order", DW'(gbits), DW'(4'b1010));
        chk("t2 cmds accepted", DW'(na), DW'(4));
        chk("t2 busy outstanding", DW'(busy), DW'(1));
        for (int k = 0; k < 4; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = DW'(8'hA0 + k);
            tick();
            chk("t2 rsp_valid", DW'(rsp_valid), DW'(1));
            chk("t2 rsp_id", DW'(rsp_id), DW'(k % 2));
            chk("t2 rsp_data", rsp_data, DW'(8'hA0 + k));
        end
        app_rd_data_valid = 1'b0;
        tick();
        chk("t2 rsp_valid drops", DW'(rsp_valid), DW'(0));
        chk("t2 busy clear", DW'(busy), DW'(0));

        // ---------------- 3: write with stalled command ----------------
        wpat = {8{32'hDEADBEEF}};
        req_addr[AW +: AW]  = 29'h100;
        req_wdata[DW +: DW] = wpat;
        req_wmask[MW +: MW] = 32'h0000_F00F;
        req_write = 2'b10;
        req_valid = 2'b10;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (req_ready == 2'b10) seen = 1;
        end
        chk("t3 write granted", DW'(seen), DW'(1));
        req_valid = 2'b00;
        tick();
        en_cnt = 0; wr_cnt = 0; cmd_cnt = 0; wdf_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            app_wdf_rdy = (c == 1);
            app_rdy     = (c == 5);
            if (app_en) en_cnt++;
            if (app_wdf_wren) wr_cnt++;
            if (app_en && app_rdy) begin
                cmd_cnt++;
                chk("t3 write addr", DW'(app_addr), DW'(29'h100));
                chk("t3 write cmd", DW'(app_cmd), DW'(3'b000));
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                wdf_cnt++;
                chk("t3 wdf data", app_wdf_data, wpat);
                chk("t3 wdf mask", DW'(app_wdf_mask), DW'(32'h0000_F00F));
                chk("t3 wdf end", DW'(app_wdf_end), DW'(1));
            end
            tick();
        end
        chk("t3 app_en cycles", DW'(en_cnt), DW'(5));
        chk("t3 wdf_wren cycles", DW'(wr_cnt), DW'(1));
        chk("t3 cmd accepts", DW'(cmd_cnt), DW'(1));
        chk("t3 wdf accepts", DW'(wdf_cnt), DW'(1));

        // ---------------- 4: tag FIFO full ----------------
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        req_write = 2'b00;
        req_valid = 2'b01;
        n0 = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (req_ready[0]) n0++;
        end
        chk("t4 reads granted until full", DW'(n0), DW'(8));
        chk("t4 busy full", DW'(busy), DW'(1));
        req_addr[AW +: AW] = 29'h200;
        req_write = 2'b10;
        req_valid = 2'b11;
        s0 = 0; s1 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_ready[1]) begin
                s1++;
                req_valid[1] = 1'b0;
            end
            if (req_ready[0]) s0++;
        end
        chk("t4 write granted while full", DW'(s1), DW'(1));
        chk("t4 ninth read blocked", DW'(s0), DW'(0));

        // ---------------- 5: reset during WR ----------------
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        req_addr[AW +: AW] = 29'h300;
        req_valid[1] = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (req_ready[1]) seen = 1;
        end
        chk("t5 write granted", DW'(seen), DW'(1));
        req_valid[1] = 1'b0;
        tick();
        chk("t5 app_en in WR", DW'(app_en), DW'(1));
        chk("t5 wdf_wren in WR", DW'(app_wdf_wren), DW'(1));
        reset = 1'b1;
        tick();
        chk("t5 app_en after reset", DW'(app_en), DW'(0));
        chk("t5 wdf_wren after reset", DW'(app_wdf_wren), DW'(0));
        chk("t5 busy after reset", DW'(busy), DW'(0));
        chk("t5 req_ready after reset", DW'(req_ready), DW'(0));
        reset = 1'b0;
        tick();
        chk("t5 no grant in WAIT_CALIB", DW'(req_ready), DW'(2'b00));
        tick();
        chk("t5 read granted after reset", DW'(req_ready), DW'(2'b01));
        req_valid = 2'b00;
        app_rdy = 1'b1;
        repeat (4) tick();

        // ---------------- 6: read data with no outstanding tag ----------------
        app_rd_data_valid = 1'b1;
        app_rd_data = DW'(8'hB0);
        tick();
        chk("t6 rsp_valid", DW'(rsp_valid), DW'(1));
        chk("t6 rsp_id", DW'(rsp_id), DW'(0));
        chk("t6 rsp_data", rsp_data, DW'(8'hB0));
        app_rd_data = DW'(8'hEE);
        tick();
        app_rd_data_valid = 1'b0;
        chk("t6 spurious rsp_valid", DW'(rsp_valid), DW'(0));
        chk("t6 busy after spurious", DW'(busy), DW'(0));
        req_addr[AW +: AW] = 29'h400;
        req_write = 2'b00;
        req_valid = 2'b10;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (req_ready[1]) seen = 1;
        end
        chk("t6 read granted", DW'(seen), DW'(1));
        req_valid = 2'b00;
        repeat (4) tick();
        app_rd_data_valid = 1'b1;
        app_rd_data = DW'(8'hC1);
        tick();
        app_rd_data_valid = 1'b0;
        chk("t6 follow-up rsp_valid", DW'(rsp_valid), DW'(1));
        chk("t6 follow-up rsp_id", DW'(rsp_id), DW'(1));
        chk("t6 follow-up rsp_data", rsp_data, DW'(8'hC1));
        tick();
        chk("t6 final busy", DW'(busy), DW'(0));
`ifdef MIG_ARB_STATS_EN
        chk("stat_err", DW'(stat_err), DW'(1));
        chk("stat_rd_cnt", DW'(stat_rd_cnt), DW'(2));
        chk("stat_wr_cnt", DW'(stat_wr_cnt), DW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mig_app_arbiter
`default_nettype wire

// File: doc/mig_app_arbiter.md
Name: mig_app_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single DDR3 MIG user (app_*) interface between NREQ requesters in the GENESYS2 FPGA test harness.
- Holds off all traffic until MIG calibration completes.
- Runs the MIG command and write-data handshakes for each request.
- Routes in-order read data back to the issuing requester through a tag FIFO.
- Sits between the fabric-side memory adapters and the MIG island.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_WIDTH, 29, MIG app_addr width
DATA_WIDTH, 256, MIG app data width
TAG_DEPTH, 8, max outstanding reads (power of 2)
IDW, 3, requester-id width; must satisfy 2**IDW >= NREQ

Ports:
clock  in  1  single clock (MIG ui_clk domain)
reset  in  1  synchronous, active-high
init_calib_complete  in  1  MIG calibration done
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_write  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_WIDTH  packed addresses
req_wdata  in  NREQ*DATA_WIDTH  packed write data
req_wmask  in  NREQ*DATA_WIDTH/8  packed byte masks (1=masked, MIG polarity)
rsp_valid  out  1  read data valid; no backpressure
rsp_id  out  IDW  requester index for rsp_data
rsp_data  out  DATA_WIDTH  read data
app_addr  out  ADDR_WIDTH  MIG address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  MIG command enable
app_rdy  in  1  MIG command accept
app_wdf_data  out  DATA_WIDTH  MIG write data
app_wdf_mask  out  DATA_WIDTH/8  MIG write mask
app_wdf_wren  out  1  MIG write-data enable
app_wdf_end  out  1  equals app_wdf_wren (one beat per burst)
app_wdf_rdy  in  1  MIG write-data accept
app_rd_data  in  DATA_WIDTH  MIG read data
app_rd_data_valid  in  1  MIG read data valid
busy  out  1  FSM not in IDLE/WAIT_CALIB or tags outstanding

Behaviour:
- All outputs registered. Reset values: req_ready=0, app_en=0, app_wdf_wren=0, rsp_valid=0, busy=0, all data/address outputs 0. Reset enters WAIT_CALIB; tag FIFO emptied; round-robin pointer set to 0.
- WAIT_CALIB: no grants. Exit to IDLE in the cycle after init_calib_complete is sampled high. If calibration drops while in IDLE, return to WAIT_CALIB. A drop mid-transaction is ignored until the transaction completes.
- IDLE arbitration: eligible = req_valid, with read requests masked when the tag FIFO is full. Round-robin starts at the index after the last grant.
- Grant: pulse req_ready for exactly one cycle, latch that requester's addr/data/mask/cmd/id, go to CMD state next cycle. Grant-to-app_en latency is 1 cycle.
- RD state: app_en=1 and app_cmd=001 held stable until app_rdy. On the accept cycle, push the latched id into the tag FIFO and return to IDLE.
- WR state: app_en and app_wdf_wren both asserted from entry. Each deasserts independently after its own handshake (app_rdy / app_wdf_rdy). Both can complete in the same cycle. Leave for IDLE once both are done.
- Read return: on app_rd_data_valid, pop the tag FIFO. Next cycle: rsp_valid=1, rsp_id=popped tag, rsp_data=registered app_rd_data.
- Push and pop in the same cycle are both honoured; count is unchanged.
- app_rd_data_valid with the tag FIFO empty is a protocol error: data is dropped, rsp_valid stays 0, sticky err flag is set (assertion in sim).
- Requesters must hold request fields stable while req_valid is high until req_ready.

Optional Feature:
MIG_ARB_STATS_EN
- Defined: adds outputs stat_wr_cnt and stat_rd_cnt (32 bits each, wrap-around) counting accepted MIG write/read commands, and stat_err (the sticky error flag). All cleared on reset.
- Undefined: these ports and counters are absent; the error flag is internal and visible only to the assertion.

Decomposition:
- Package mig_arb_pkg: MIG command encodings (CMD_WR=3'b000, CMD_RD=3'b001), FSM state enum (WAIT_CALIB, IDLE, RD, WR), helper function for round-robin next index.
- Sub-module mig_arb_tag_fifo: synchronous FIFO, TAG_DEPTH x IDW, with full/empty/simultaneous push-pop handling.

Test Plan:
1. init_calib_complete held 0 for 100 cycles with req_valid=2'b11 -> no req_ready, no app_en. Raise calibration -> first grant to requester 0 two cycles later.
2. Both requesters issue continuous reads, app_rdy=1 -> grants alternate 0,1,0,1. Responses returned with rsp_id 0,1,0,1 for data 0xA0..0xA3.
3. Write, app_rdy stalled 5 cycles, app_wdf_rdy=1 at cycle 1 -> wdf_wren drops after cycle 1, app_en held 5 cycles, exactly one write at addr 0x100 with the correct mask.
4. Delay app_rd_data_valid until 8 reads are outstanding -> 9th read not granted; a pending write from the other requester is still granted.
5. Pulse reset mid-WR state -> next cycle app_en=0, app_wdf_wren=0, FSM in WAIT_CALIB, tag FIFO empty.
6. app_rd_data_valid with no outstanding read -> rsp_valid stays 0, assertion fires (stat_err=1 with MIG_ARB_STATS_EN).
